tilelink_ul_master: RTL

- TileLink-UL initiator: converts a simple command/response interface into A-channel requests and consumes D-channel responses.
- Drives a tilelink_ul_slave_top-style responder; used by CPU-side glue and as a reusable bench driver.
- Exactly one outstanding transaction.
- Source ID rotates per request; D responses are checked against the expected source and opcode.

---
 rtl/tilelink_ul_master.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/tilelink_ul_master.sv
// TileLink-UL initiator: one outstanding Get/Put, rotating source ID, D-beat checking.
// Optional D-wait timeout is enabled by defining TL_MASTER_TIMEOUT_EN.
module tilelink_ul_master #(
  parameter int unsigned TL_ADDR_WIDTH   = 64,
  parameter int unsigned TL_DATA_WIDTH   = 64,
  parameter int unsigned TL_STRB_WIDTH   = TL_DATA_WIDTH / 8,
  parameter int unsigned TL_SOURCE_WIDTH = 3,
  parameter int unsigned TL_SINK_WIDTH   = 3,
  parameter int unsigned TL_OPCODE_WIDTH = 3,
  parameter int unsigned TL_PARAM_WIDTH  = 3,
  parameter int unsigned TL_SIZE_WIDTH   = 8,
  parameter int unsigned TIMEOUT_CYCLES  = 256
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic                       cmd_write,
  input  logic [TL_ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [TL_SIZE_WIDTH-1:0]   cmd_size,
  input  logic [TL_STRB_WIDTH-1:0]   cmd_mask,
  input  logic [TL_DATA_WIDTH-1:0]   cmd_wdata,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [TL_DATA_WIDTH-1:0]   rsp_rdata,
  output logic                       rsp_error,
  output logic                       a_valid,
  input  logic                       a_ready,
  output logic [TL_OPCODE_WIDTH-1:0] a_opcode,
  output logic [TL_PARAM_WIDTH-1:0]  a_param,
  output logic [TL_ADDR_WIDTH-1:0]   a_address,
  output logic [TL_SIZE_WIDTH-1:0]   a_size,
  output logic [TL_STRB_WIDTH-1:0]   a_mask,
  output logic [TL_DATA_WIDTH-1:0]   a_data,
  output logic [TL_SOURCE_WIDTH-1:0] a_source,
  input  logic                       d_valid,
  output logic                       d_ready,
  input  logic [TL_OPCODE_WIDTH-1:0] d_opcode,
  input  logic [TL_PARAM_WIDTH-1:0]  d_param,
  input  logic [TL_SIZE_WIDTH-1:0]   d_size,
  input  logic [TL_SINK_WIDTH-1:0]   d_sink,
  input  logic [TL_SOURCE_WIDTH-1:0] d_source,
  input  logic [TL_DATA_WIDTH-1:0]   d_data,
  input  logic                       d_error
);

  localparam logic [TL_OPCODE_WIDTH-1:0] OP_PUT_FULL    = TL_OPCODE_WIDTH'(0);
  localparam logic [TL_OPCODE_WIDTH-1:0] OP_PUT_PARTIAL = TL_OPCODE_WIDTH'(1);
  localparam logic [TL_OPCODE_WIDTH-1:0] OP_GET         = TL_OPCODE_WIDTH'(4);
  localparam logic [TL_OPCODE_WIDTH-1:0] OP_ACK         = TL_OPCODE_WIDTH'(0);
  localparam logic [TL_OPCODE_WIDTH-1:0] OP_ACK_DATA    = TL_OPCODE_WIDTH'(1);

  typedef enum logic [1:0] {IDLE, A_REQ, D_WAIT, RSP} state_e;

  state_e                     state_q;
  logic [TL_SOURCE_WIDTH-1:0] src_q;
  logic                       write_q;
  logic                       cmd_ready_q;
  logic                       a_valid_q;
  logic [TL_OPCODE_WIDTH-1:0] a_opcode_q;
  logic [TL_ADDR_WIDTH-1:0]   a_address_q;
  logic [TL_SIZE_WIDTH-1:0]   a_size_q;
  logic [TL_STRB_WIDTH-1:0]   a_mask_q;
  logic [TL_DATA_WIDTH-1:0]   a_data_q;
  logic [TL_SOURCE_WIDTH-1:0] a_source_q;
  logic                       d_ready_q;
  logic                       rsp_valid_q;
  logic [TL_DATA_WIDTH-1:0]   rsp_rdata_q;
  logic                       rsp_error_q;

`ifdef TL_MASTER_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES) + 1;
  logic [TO_W-1:0] to_cnt_q;
`endif

  // Sideband D fields carry no information for a single-beat UL initiator.
  logic unused_inputs;
  assign unused_inputs = ^{d_param, d_size, d_sink, 32'(TIMEOUT_CYCLES)};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      src_q       <= '0;
      write_q     <= 1'b0;
      cmd_ready_q <= 1'b1;
      a_valid_q   <= 1'b0;
      a_opcode_q  <= '0;
      a_address_q <= '0;
      a_size_q    <= '0;
      a_mask_q    <= '0;
      a_data_q    <= '0;
      a_source_q  <= '0;
      d_ready_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_error_q <= 1'b0;
`ifdef TL_MASTER_TIMEOUT_EN
      to_cnt_q    <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (cmd_valid) begin
            cmd_ready_q <= 1'b0;
            a_valid_q   <= 1'b1;
            write_q     <= cmd_write;
            a_address_q <= cmd_addr;
            a_size_q    <= cmd_size;
            a_mask_q    <= cmd_mask;
            a_source_q  <= src_q;
            if (cmd_write) begin
              a_opcode_q <= (&cmd_mask) ? OP_PUT_FULL : OP_PUT_PARTIAL;
              a_data_q   <= cmd_wdata;
            end else begin
              a_opcode_q <= OP_GET;
              a_data_q   <= '0;
            end
            state_q <= A_REQ;
          end
        end
        A_REQ: begin
          if (a_ready) begin
            a_valid_q <= 1'b0;
            d_ready_q <= 1'b1;
            src_q     <= src_q + TL_SOURCE_WIDTH'(1);
`ifdef TL_MASTER_TIMEOUT_EN
            to_cnt_q  <= '0;
`endif
            state_q   <= D_WAIT;
          end
        end
        D_WAIT: begin
          if (d_valid) begin
            d_ready_q   <= 1'b0;
            rsp_valid_q <= 1'b1;
            rsp_rdata_q <= write_q ? '0 : d_data;
            rsp_error_q <= d_error || (d_source != a_source_q) ||
                           (d_opcode != (write_q ? OP_ACK : OP_ACK_DATA));
            state_q     <= RSP;
          end
`ifdef TL_MASTER_TIMEOUT_EN
          // Give up on a missing D beat and report it as an error response.
          else if (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
            d_ready_q   <= 1'b0;
            rsp_valid_q <= 1'b1;
            rsp_rdata_q <= '0;
            rsp_error_q <= 1'b1;
            state_q     <= RSP;
          end else begin
            to_cnt_q <= to_cnt_q + TO_W'(1);
          end
`endif
        end
        RSP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            cmd_ready_q <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign a_valid   = a_valid_q;
  assign a_opcode  = a_opcode_q;
  assign a_param   = '0;
  assign a_address = a_address_q;
  assign a_size    = a_size_q;
  assign a_mask    = a_mask_q;
  assign a_data    = a_data_q;
  assign a_source  = a_source_q;
  assign d_ready   = d_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_error = rsp_error_q;

endmodule
